// File: rtl/cam_dvp_tx_if.sv
// Pixel-stream and DVP byte bus grouped for cam_dvp_tx.
// master = the transmitter, slave = the upstream source / DVP sink side.
interface cam_dvp_tx_if;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_data;

  modport master (
    input  pix_data, pix_valid,
    output pix_ready, dvp_vsync, dvp_href, dvp_data
  );

  modport slave (
    output pix_data, pix_valid,
    input  pix_ready, dvp_vsync, dvp_href, dvp_data
  );
endinterface

// File: rtl/cam_dvp_tx.sv
// DVP transmitter: RGB565 pixels (stream or colour bars) to an 8-bit vsync/href byte stream.
// state | meaning
// IDLE  | counters parked at 0, all DVP outputs low, waiting for tx_en
// RUN   | counters free-run; leaves only on the last cycle of a frame
module cam_dvp_tx #(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 160,
  parameter int V_ACTIVE  = 480,
  parameter int VSYNC_LEN = 4,
  parameter int V_BACK    = 16,
  parameter int V_FRONT   = 4
) (
  input  logic                cam_pclk,
  input  logic                cam_data_asy_rst,
  input  logic                tx_en,
  input  logic                pat_sel,
  cam_dvp_tx_if.master        dvp,
  output logic                frame_start,
  output logic [15:0]         frame_cnt,
  output logic                underflow
);

  localparam int LINE  = 2*H_ACTIVE + H_BLANK;
  localparam int FRAME = VSYNC_LEN + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_W   = $clog2(LINE + 1);
  localparam int V_W   = $clog2(FRAME + 1);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int B_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [H_W-1:0] H_LAST    = H_W'(LINE - 1);
  localparam logic [H_W-1:0] H_ACT_END = H_W'(2*H_ACTIVE);
  localparam logic [V_W-1:0] V_LAST    = V_W'(FRAME - 1);
  localparam logic [V_W-1:0] VS_END    = V_W'(VSYNC_LEN);
  localparam logic [V_W-1:0] ACT_BEG   = V_W'(VSYNC_LEN + V_BACK);
  localparam logic [V_W-1:0] ACT_END   = V_W'(VSYNC_LEN + V_BACK + V_ACTIVE);
  localparam logic [B_W-1:0] BAR_LAST  = B_W'(BAR_W - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  logic [1:0]     rst_sync_q;
  logic           rst_s;
  state_e         state_q;
  logic [H_W-1:0] h_cnt_q;
  logic [V_W-1:0] v_cnt_q;
  logic           pat_frame_q;
  logic           vsync_q;
  logic           href_q;
  logic [7:0]     data_q;
  logic [7:0]     pix_reg_q;
  logic           fstart_q;
  logic [15:0]    frame_cnt_q;
  logic           underflow_q;
  logic [2:0]     bar_q;
  logic [B_W-1:0] px_left_q;

  logic           run;
  logic           h_last;
  logic           v_last;
  logic           vs_region;
  logic           act_line;
  logic           act_byte;
  logic           fetch;
  logic           pat_frame_d;
  logic [15:0]    bar_color_d;
  logic [15:0]    sel_pix_d;

  // Assert asynchronously, release two clocks after the raw reset drops.
  always_ff @(posedge cam_pclk or posedge cam_data_asy_rst) begin
    if (cam_data_asy_rst) rst_sync_q <= 2'b11;
    else                  rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_s = rst_sync_q[1];

  assign run       = (state_q == RUN);
  assign h_last    = (h_cnt_q == H_LAST);
  assign v_last    = (v_cnt_q == V_LAST);
  assign vs_region = (v_cnt_q < VS_END);
  assign act_line  = (v_cnt_q >= ACT_BEG) && (v_cnt_q < ACT_END);
  assign act_byte  = act_line && (h_cnt_q < H_ACT_END);
  assign fetch     = run && act_byte && !h_cnt_q[0];

  assign pat_frame_d = (run && h_cnt_q == '0 && v_cnt_q == '0) ? pat_sel : pat_frame_q;

  always_comb begin
    bar_color_d = 16'h0000;
    case (bar_q)
      3'd0: bar_color_d = 16'hFFFF;
      3'd1: bar_color_d = 16'hFFE0;
      3'd2: bar_color_d = 16'h07FF;
      3'd3: bar_color_d = 16'h07E0;
      3'd4: bar_color_d = 16'hF81F;
      3'd5: bar_color_d = 16'hF800;
      3'd6: bar_color_d = 16'h001F;
      default: bar_color_d = 16'h0000;
    endcase
  end

  assign sel_pix_d = pat_frame_q ? bar_color_d
                   : (dvp.pix_valid ? dvp.pix_data : 16'h0000);

  always_ff @(posedge cam_pclk or posedge rst_s) begin
    if (rst_s) begin
      state_q     <= IDLE;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      pat_frame_q <= 1'b0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= 8'h00;
      pix_reg_q   <= 8'h00;
      fstart_q    <= 1'b0;
      frame_cnt_q <= 16'h0000;
      underflow_q <= 1'b0;
      bar_q       <= 3'd0;
      px_left_q   <= '0;
    end else begin
      pat_frame_q <= pat_frame_d;

      case (state_q)
        IDLE: begin
          h_cnt_q <= '0;
          v_cnt_q <= '0;
          if (tx_en) state_q <= RUN;
        end
        RUN: begin
          if (h_last) begin
            h_cnt_q <= '0;
            if (v_last) begin
              v_cnt_q <= '0;
              if (!tx_en) state_q <= IDLE;
            end else begin
              v_cnt_q <= v_cnt_q + V_W'(1);
            end
          end else begin
            h_cnt_q <= h_cnt_q + H_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      vsync_q  <= run && vs_region;
      href_q   <= run && act_byte;
      fstart_q <= run && vs_region && !vsync_q;
      if (run && vs_region && !vsync_q) frame_cnt_q <= frame_cnt_q + 16'd1;

      // High byte goes out the cycle after fetch; low byte waits one more in pix_reg.
      if (fetch) begin
        data_q    <= sel_pix_d[15:8];
        pix_reg_q <= sel_pix_d[7:0];
        if (!pat_frame_q && !dvp.pix_valid) underflow_q <= 1'b1;
      end else if (run && act_byte) begin
        data_q <= pix_reg_q;
      end else begin
        data_q <= 8'h00;
      end

      // Bar tracker replaces a divide by H_ACTIVE/8 on the pixel index.
      if (fetch) begin
        if (px_left_q == '0) begin
          bar_q     <= bar_q + 3'd1;
          px_left_q <= BAR_LAST;
        end else begin
          px_left_q <= px_left_q - B_W'(1);
        end
      end else if (!(run && act_byte)) begin
        bar_q     <= 3'd0;
        px_left_q <= BAR_LAST;
      end
    end
  end

  assign dvp.pix_ready = fetch && !pat_frame_q;
  assign dvp.dvp_vsync = vsync_q;
  assign dvp.dvp_href  = href_q;
  assign dvp.dvp_data  = data_q;
  assign frame_start   = fstart_q;
  assign frame_cnt     = frame_cnt_q;
  assign underflow     = underflow_q;

endmodule

// File: doc/cam_dvp_tx.md
Name: cam_dvp_tx

Overview:
- DVP camera-interface transmitter: turns 16-bit RGB565 pixels into an OV5640-style 8-bit byte stream with vsync/href framing.
- Byte order per pixel: high byte first, then low byte.
- Used as a sensor emulator in simulation and board bring-up, and as a DVP source into the camera receive path.
- Pixel source is either an upstream valid/ready stream or an internal 8-bar colour pattern.

Parameters:
- H_ACTIVE, 640, active pixels per line (even; multiple of 8).
- H_BLANK, 160, pclk cycles of href-low blanking per line.
- V_ACTIVE, 480, active lines per frame.
- VSYNC_LEN, 4, lines with vsync high at frame start.
- V_BACK, 16, lines between vsync falling and first active line.
- V_FRONT, 4, lines after last active line before next frame.

Ports:
- cam_pclk  in  1  pixel/byte clock
- cam_data_asy_rst  in  1  asynchronous, active-high reset
- tx_en  in  1  run request
- pat_sel  in  1  1 = internal colour bars, 0 = pix_* stream
- pix_data  in  16  RGB565 pixel from upstream
- pix_valid  in  1  upstream pixel valid
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- dvp_vsync  out  1  frame sync, active high
- dvp_href  out  1  line valid, high for 2*H_ACTIVE cycles per active line
- dvp_data  out  8  byte data
- frame_start  out  1  one-cycle pulse coincident with the rising edge of dvp_vsync
- frame_cnt  out  16  frames started, wraps at 16'hFFFF -> 0
- underflow  out  1  sticky; cleared only by reset

Behaviour:
- Reset handling:
  - cam_data_asy_rst is asserted asynchronously and released synchronously through a 2-flop synchroniser on cam_pclk.
  - All logic uses the synchronised reset.
  - Reset values: every output 0; state IDLE; counters 0.
- Timing constants:
  - LINE = 2*H_ACTIVE + H_BLANK cycles.
  - FRAME = VSYNC_LEN + V_BACK + V_ACTIVE + V_FRONT lines.
- Counters:
  - h_cnt runs 0..LINE-1; v_cnt runs 0..FRAME-1.
  - Both advance only in RUN; v_cnt increments when h_cnt wraps.
- State machine:
  - IDLE: counters held at 0; dvp_* and pix_ready held 0. If tx_en = 1, go to RUN; the first RUN cycle has h_cnt = v_cnt = 0.
  - RUN: counters free-run. On the last cycle of a frame (h_cnt = LINE-1, v_cnt = FRAME-1): if tx_en = 0 go to IDLE, else wrap to 0 and start the next frame.
  - Deasserting tx_en mid-frame always completes the current frame; a frame is never truncated.
- pat_sel is sampled at h_cnt = v_cnt = 0 of each frame and held for the whole frame.
- Region decode (combinational, from the counters):
  - vs_region = v_cnt < VSYNC_LEN.
  - act_line = VSYNC_LEN+V_BACK <= v_cnt < VSYNC_LEN+V_BACK+V_ACTIVE.
  - act_byte = act_line && h_cnt < 2*H_ACTIVE.
- Outputs (registered; 1-cycle latency from counter state):
  - dvp_vsync = vs_region delayed 1 cycle.
  - dvp_href = act_byte delayed 1 cycle.
  - frame_start = 1 on the cycle dvp_vsync goes 0 -> 1; frame_cnt increments on that same edge.
- Pixel fetch:
  - pix_ready = RUN && act_byte && h_cnt[0] = 0 && pat_sel_frame = 0 (combinational).
  - On that cycle the pixel is latched into pix_reg. If pix_valid = 0, pix_reg <= 16'h0000 and underflow <= 1.
  - dvp_data on the next cycle = the selected pixel [15:8]; on the cycle after = pix_reg[7:0].
- Colour pattern (pat_sel_frame = 1):
  - pix_ready stays 0 and underflow is not touched.
  - pixel index = h_cnt>>1; bar = pixel index / (H_ACTIVE/8).
  - Bar colours 0..7: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- When dvp_href = 0, dvp_data = 8'h00.
- Simultaneous events: tx_en rising in the same cycle as reset release is ignored until the reset synchroniser has deasserted.
- Reset asserted mid-frame: outputs drop to 0 immediately (async); the next frame starts from v_cnt = 0 after release.

Test Plan:
All scenarios use H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VSYNC_LEN=1, V_BACK=1, V_FRONT=1, giving LINE=20 and FRAME=7 (140 cycles/frame).
- Reset then tx_en=1, pat_sel=1 -> frame_start pulse 1 cycle after the RUN entry cycle; dvp_vsync high 20 cycles; 4 href pulses of 16 cycles, 4 cycles apart; frame_cnt=1. Bytes per line: FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
- Stream mode, pix_valid=1 with pixels 16'h1234, 16'h5678 -> dvp_data 12,34,56,78 on consecutive href-high cycles; 32 handshakes per frame; underflow stays 0.
- Stream mode, pix_valid=0 on the 3rd pixel slot -> bytes 00,00 at positions 4-5 of that line; underflow=1 and remains set through later frames.
- Drop tx_en at v_cnt=3 -> frame completes all 140 cycles, then IDLE; no further vsync; frame_cnt stays 1.
- Assert reset at mid-line href high -> all outputs 0 on the same edge; after release plus tx_en, first frame_start occurs with frame_cnt=1.
- 65536 frame starts (forced counter preload 16'hFFFF) -> frame_cnt wraps to 0 at the next frame_start.
